four_bit_down_counter: RTL and testbench

Programmable 4-bit synchronous down counter (countdown timer) with parallel load, JK-style mode control, optional auto-reload and a one-cycle borrow pulse. It is the counterpart of the team's 4-bit JK binary up counter: the up counter measures elapsed cycles, and this block counts a loaded interval back down to zero. It sits beside the up counter in the same counter/timer designs and can be cascaded through `borrow`.

---
 rtl/four_bit_down_counter.sv | 124 ++++++++++++
 tb/tb_four_bit_down_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/four_bit_down_counter.sv
// rtl/four_bit_down_counter.sv - programmable down counter with load, JK mode control, auto-reload and borrow pulse
//
// Counts a loaded interval back down to zero and flags terminal count with a
// one-cycle registered borrow pulse. It can be cascaded through borrow.
//
// Parameters:
//   WIDTH       counter width (4 is the verified configuration)
//   AUTO_RELOAD 1: reload from reload register on terminal count; 0: stop at zero
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          enable for J/K mode operations (load ignores it)
//   load        synchronous parallel load strobe, highest priority after rst
//   load_value  value captured into count and the reload register on load
//   J, K        mode: 00 hold, 01 clear, 10 preset to all ones, 11 count down
//   count       registered counter value
//   borrow      registered terminal-count pulse, one cycle wide
//   zero        combinational count == 0
//   busy        high while the FSM is in RUN

module four_bit_down_counter #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             J,
    input  logic             K,
    output logic [WIDTH-1:0] count,
    output logic             borrow,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;

    logic             is_terminal;
    logic             reload_ok;

    assign is_terminal = (count_q == WIDTH'(1));
    // Reloading a zero interval would park the counter in RUN at 0, so a
    // zero reload register always falls back to the stop-at-zero behaviour.
    assign reload_ok   = AUTO_RELOAD && (reload_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? S_RUN : S_DONE;
        end else if (en) begin
            unique case ({J, K})
                2'b00: begin
                end
                2'b01: begin
                    count_d = '0;
                    state_d = S_DONE;
                end
                2'b10: begin
                    count_d = '1;
                    state_d = S_RUN;
                end
                2'b11: begin
                    // Only RUN decrements; IDLE and DONE hold so 0 never wraps.
                    if (state_q == S_RUN) begin
                        if (is_terminal) begin
                            borrow_d = 1'b1;
                            if (reload_ok) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = S_DONE;
                            end
                        end else if (count_q == '0) begin
                            // RUN never holds 0 by construction; retire quietly if it does.
                            state_d = S_DONE;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count  = count_q;
    assign borrow = borrow_q;
    assign zero   = (count_q == '0);
    assign busy   = (state_q == S_RUN);

endmodule

// File: tb/tb_four_bit_down_counter.sv
// tb/tb_four_bit_down_counter.sv - directed vector bench for four_bit_down_counter
module tb_four_bit_down_counter;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       j;
        logic       k;
        logic [3:0] c;
        logic       b;
        logic       bz;
        logic       z;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       J = 1'b0;
    logic       K = 1'b0;

    logic [3:0] count_s, count_a;
    logic       borrow_s, borrow_a;
    logic       zero_s, zero_a;
    logic       busy_s, busy_a;

    int checks = 0;
    int failures = 0;

    vec_t main_q[$];
    vec_t ar_q[$];

    four_bit_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
        .J(J), .K(K), .count(count_s), .borrow(borrow_s), .zero(zero_s), .busy(busy_s)
    );

    four_bit_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_ar (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
        .J(J), .K(K), .count(count_a), .borrow(borrow_a), .zero(zero_a), .busy(busy_a)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [3:0] lv, input logic e,
                                input logic j, input logic k, input logic [3:0] c,
                                input logic b, input logic bz, input logic z);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.j = j; v.k = k;
        v.c = c; v.b = b; v.bz = bz; v.z = z;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic ar, input logic [3:0] c,
                            input logic b, input logic bz, input logic z);
        chk({name, ".count"},  ar ? int'(count_a)  : int'(count_s),  int'(c));
        chk({name, ".borrow"}, ar ? int'(borrow_a) : int'(borrow_s), int'(b));
        chk({name, ".busy"},   ar ? int'(busy_a)   : int'(busy_s),   int'(bz));
        chk({name, ".zero"},   ar ? int'(zero_a)   : int'(zero_s),   int'(z));
    endtask

    task automatic drive(input logic ld, input logic [3:0] lv, input logic e,
                         input logic j, input logic k);
        load = ld; load_value = lv; en = e; J = j; K = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input logic ar, input vec_t v);
        drive(v.ld, v.lv, v.en, v.j, v.k);
        step();
        chk_outs(name, ar, v.c, v.b, v.bz, v.z);
    endtask

    task automatic pulse_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Plain stop-at-zero instance: countdown, mode controls, simultaneous events.
        main_q.push_back(mk(1, 4'd5, 0, 0, 0, 4'd5, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd4, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd3, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd2, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd1, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd0, 1, 0, 1));
        for (int i = 0; i < 4; i++)
            main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 1));
        main_q.push_back(mk(1, 4'd6, 0, 0, 0, 4'd6, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 0, 1, 4'd0, 0, 0, 1));
        main_q.push_back(mk(0, 4'd0, 1, 1, 0, 4'hF, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            main_q.push_back(mk(0, 4'd0, 0, 1, 1, 4'hF, 0, 1, 0));
        main_q.push_back(mk(1, 4'd1, 0, 0, 0, 4'd1, 0, 1, 0));
        main_q.push_back(mk(1, 4'd9, 1, 1, 1, 4'd9, 0, 1, 0));
        main_q.push_back(mk(1, 4'd0, 1, 1, 1, 4'd0, 0, 0, 1));
        main_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 1));
        main_q.push_back(mk(1, 4'd1, 0, 0, 0, 4'd1, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 1, 0, 4'hF, 0, 1, 0));
        main_q.push_back(mk(0, 4'd0, 1, 0, 0, 4'hF, 0, 1, 0));

        // Auto-reload instance: 3 loaded, then nine count-down cycles.
        ar_q.push_back(mk(1, 4'd3, 0, 0, 0, 4'd3, 0, 1, 0));
        for (int r = 0; r < 3; r++) begin
            ar_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd2, 0, 1, 0));
            ar_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd1, 0, 1, 0));
            ar_q.push_back(mk(0, 4'd0, 1, 1, 1, 4'd3, 1, 1, 0));
        end

        #1 rst = 1'b1;
        #2;
        chk_outs("reset_plain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_outs("reset_ar", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        rst = 1'b0;

        // Count-down with reset in IDLE must hold.
        run_vec("idle_hold", 1'b0, mk(0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 1));

        foreach (main_q[i])
            run_vec($sformatf("main[%0d]", i), 1'b0, main_q[i]);

        // Asynchronous reset mid-cycle at count 7, checked before the next edge.
        run_vec("load7", 1'b0, mk(1, 4'd7, 0, 0, 0, 4'd7, 0, 1, 0));
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        rst = 1'b0;

        // Reset held across what would be a terminal edge: no borrow.
        run_vec("load1", 1'b0, mk(1, 4'd1, 0, 0, 0, 4'd1, 0, 1, 0));
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        #2 rst = 1'b1;
        step();
        chk_outs("rst_abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        pulse_reset();
        foreach (ar_q[i])
            run_vec($sformatf("ar[%0d]", i), 1'b1, ar_q[i]);

        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
